// File: rtl/fft64_pkg.sv
// Shared constants and twiddle index mapping for the 64-point 8x8 twiddle multiplier.
package fft64_pkg;

  localparam int unsigned TW_N     = 64;
  localparam int unsigned TW_QSIZE = 16;
  localparam int unsigned TW_HALFQ = 8;

  // Quadrant, swap flag and base-constant select for one twiddle index
  typedef struct packed {
    logic [1:0] q;
    logic       swap;
    logic [3:0] sel;
  } tw_map_t;

  // idx = row * col of the 8x8 decomposition; reflect the upper half of each
  // quadrant back onto base angles 0..8 and flag it as a cos/sin swap
  function automatic tw_map_t tw_map(input logic [5:0] eff);
    tw_map_t    m;
    logic [5:0] idx;
    logic [3:0] r;
    logic [4:0] refl;
    idx    = {3'b000, eff[5:3]} * {3'b000, eff[2:0]};
    r      = idx[3:0];
    refl   = 5'(TW_QSIZE) - {1'b0, r};
    m.q    = idx[5:4];
    m.swap = (r > 4'(TW_HALFQ));
    m.sel  = m.swap ? refl[3:0] : r;
    return m;
  endfunction

endpackage

// File: rtl/twiddle64_rotate.sv
// Combinational swap, quadrant rotation, rounding and saturation of the
// base-angle partial products.
module twiddle64_rotate
  import fft64_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned OUT_SHIFT  = 1
) (
  input  logic signed [DATA_WIDTH:0]   rere,
  input  logic signed [DATA_WIDTH:0]   imim,
  input  logic signed [DATA_WIDTH:0]   reim,
  input  logic signed [DATA_WIDTH:0]   imre,
  input  logic                         swap,
  input  logic [1:0]                   q,
  output logic signed [DATA_WIDTH-1:0] res_real,
  output logic signed [DATA_WIDTH-1:0] res_imag,
  output logic                         sat
);

  localparam int unsigned PW    = DATA_WIDTH + 1;
  localparam int unsigned SW    = DATA_WIDTH + 2;
  localparam int unsigned NW    = DATA_WIDTH + 3;
  localparam int          RND_I = (OUT_SHIFT == 0) ? 0 : (1 << (OUT_SHIFT - 1));
  localparam logic signed [NW-1:0] RND  = NW'(RND_I);
  localparam logic signed [NW-1:0] MAXV = NW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [NW-1:0] MINV = -MAXV - NW'(1);

  logic signed [PW-1:0] cr, sr, ci, si;
  logic signed [SW-1:0] y0r, y0i;
  logic signed [NW-1:0] yr, yi, vr, vi, rr, ri;
  logic                 sat_r, sat_i;

  // Reflected half-quadrant: cos and sin products trade places
  always_comb begin
    if (swap) begin
      cr = reim;
      sr = rere;
      ci = imim;
      si = imre;
    end else begin
      cr = rere;
      sr = reim;
      ci = imre;
      si = imim;
    end
  end

  // Complex multiply by base angle, then rotate by q * 90 deg
  always_comb begin
    y0r = {cr[PW-1], cr} + {si[PW-1], si};
    y0i = {ci[PW-1], ci} - {sr[PW-1], sr};
    yr  = {y0r[SW-1], y0r};
    yi  = {y0i[SW-1], y0i};
    unique case (q)
      2'd0: begin vr = yr;  vi = yi;  end
      2'd1: begin vr = yi;  vi = -yr; end
      2'd2: begin vr = -yr; vi = -yi; end
      default: begin vr = -yi; vi = yr; end
    endcase
    rr = (vr + RND) >>> OUT_SHIFT;
    ri = (vi + RND) >>> OUT_SHIFT;
  end

  // Clamp each part to the output range and flag any clipping
  always_comb begin
    sat_r    = 1'b0;
    sat_i    = 1'b0;
    res_real = rr[DATA_WIDTH-1:0];
    res_imag = ri[DATA_WIDTH-1:0];
    if (rr > MAXV) begin
      res_real = MAXV[DATA_WIDTH-1:0];
      sat_r    = 1'b1;
    end else if (rr < MINV) begin
      res_real = MINV[DATA_WIDTH-1:0];
      sat_r    = 1'b1;
    end
    if (ri > MAXV) begin
      res_imag = MAXV[DATA_WIDTH-1:0];
      sat_i    = 1'b1;
    end else if (ri < MINV) begin
      res_imag = MINV[DATA_WIDTH-1:0];
      sat_i    = 1'b1;
    end
    sat = sat_r | sat_i;
  end

endmodule

// File: rtl/twiddle64_part2.sv
// Back end of the 64-point shift-add twiddle multiplier: sequences the twiddle
// index, selects the upstream base constant and registers the rotated product.
module twiddle64_part2
  import fft64_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned OUT_SHIFT  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_sop,
  output logic [3:0]                   const_sel,
  input  logic signed [DATA_WIDTH:0]   p_rere,
  input  logic signed [DATA_WIDTH:0]   p_imim,
  input  logic signed [DATA_WIDTH:0]   p_reim,
  input  logic signed [DATA_WIDTH:0]   p_imre,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic signed [DATA_WIDTH-1:0] dout_real,
  output logic signed [DATA_WIDTH-1:0] dout_imag,
  output logic                         sat_flag
);

  logic [5:0] cnt_q, cnt_d, eff;
  tw_map_t    map;

  logic signed [DATA_WIDTH:0] rere_q, imim_q, reim_q, imre_q;
  logic                       swap_q, sop1_q, v1_q;
  logic [1:0]                 q_q;

  logic signed [DATA_WIDTH-1:0] res_real, res_imag, real_q, imag_q;
  logic                         sat, ov_q, os_q, sat_q;

  // in_sop forces index 0 so the same-cycle constant select is already right
  always_comb begin
    eff       = in_sop ? 6'd0 : cnt_q;
    map       = tw_map(eff);
    const_sel = map.sel;
    cnt_d     = in_valid ? eff + 6'd1 : cnt_q;
  end

  // Sample counter; 6-bit increment wraps 63 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stage 1: capture products and mapping; valid bit also clocks bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rere_q <= '0;
      imim_q <= '0;
      reim_q <= '0;
      imre_q <= '0;
      swap_q <= 1'b0;
      q_q    <= '0;
      sop1_q <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        rere_q <= p_rere;
        imim_q <= p_imim;
        reim_q <= p_reim;
        imre_q <= p_imre;
        swap_q <= map.swap;
        q_q    <= map.q;
        sop1_q <= in_sop;
      end
    end
  end

  twiddle64_rotate #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_rotate (
    .rere    (rere_q),
    .imim    (imim_q),
    .reim    (reim_q),
    .imre    (imre_q),
    .swap    (swap_q),
    .q       (q_q),
    .res_real(res_real),
    .res_imag(res_imag),
    .sat     (sat)
  );

  // Stage 2: output registers; data holds across bubbles, flags pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      os_q   <= 1'b0;
      sat_q  <= 1'b0;
      real_q <= '0;
      imag_q <= '0;
    end else begin
      ov_q  <= v1_q;
      os_q  <= v1_q & sop1_q;
      sat_q <= v1_q & sat;
      if (v1_q) begin
        real_q <= res_real;
        imag_q <= res_imag;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_sop   = os_q;
  assign sat_flag  = sat_q;
  assign dout_real = real_q;
  assign dout_imag = imag_q;

endmodule

// File: tb/tb_twiddle64_part2.sv
// Scoreboard bench for twiddle64_part2: stimulus pushes hand-computed results,
// an independent monitor pops them when out_valid is seen.
module tb_twiddle64_part2;

  localparam int DW = 14;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_sop;
  logic [3:0]           const_sel;
  logic signed [DW:0]   p_rere, p_imim, p_reim, p_imre;
  logic                 out_valid, out_sop, sat_flag;
  logic signed [DW-1:0] dout_real, dout_imag;

  twiddle64_part2 #(
    .DATA_WIDTH(DW),
    .OUT_SHIFT (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .const_sel(const_sel),
    .p_rere   (p_rere),
    .p_imim   (p_imim),
    .p_reim   (p_reim),
    .p_imre   (p_imre),
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .dout_real(dout_real),
    .dout_imag(dout_imag),
    .sat_flag (sat_flag)
  );

  typedef struct {
    logic sop;
    int   re;
    int   im;
    logic sat;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   last_r = 0;
  int   last_i = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference select: base angle index folded onto 0..8
  function automatic int ref_sel(input int eff);
    int idx, r;
    idx = (eff / 8) * (eff % 8);
    r   = idx % 16;
    return (r <= 8) ? r : 16 - r;
  endfunction

  // One valid sample: drive, check const_sel, push the expected output
  task automatic send(input logic sop, input int rere, input int imim, input int reim,
                      input int imre, input int er, input int ei, input logic esat);
    exp_t e;
    int   eff;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sop   = sop;
    p_rere   = (DW + 1)'(rere);
    p_imim   = (DW + 1)'(imim);
    p_reim   = (DW + 1)'(reim);
    p_imre   = (DW + 1)'(imre);
    eff      = sop ? 0 : model_cnt;
    e.sop    = sop;
    e.re     = er;
    e.im     = ei;
    e.sat    = esat;
    e.cyc    = cyc + 2;
    sb.push_back(e);
    model_cnt = (eff + 1) % 64;
    #1;
    chk($sformatf("const_sel eff=%0d", eff), int'(const_sel), ref_sel(eff));
  endtask

  // Bubble cycle with junk on the product inputs
  task automatic idle(input logic sop);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = sop;
    p_rere   = (DW + 1)'(1234);
    p_imim   = (DW + 1)'(-4321);
    p_reim   = (DW + 1)'(777);
    p_imre   = (DW + 1)'(-999);
  endtask

  // Monitor: pop on every output beat, check hold and pulse behaviour on bubbles
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid=1 expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency_cyc", cyc, e.cyc);
          chk("out_sop", int'(out_sop), int'(e.sop));
          chk("dout_real", int'(dout_real), e.re);
          chk("dout_imag", int'(dout_imag), e.im);
          chk("sat_flag", int'(sat_flag), int'(e.sat));
          last_r = e.re;
          last_i = e.im;
        end
      end else begin
        chk("hold_real", int'(dout_real), last_r);
        chk("hold_imag", int'(dout_imag), last_i);
        chk("bubble_sat", int'(sat_flag), 0);
        chk("bubble_sop", int'(out_sop), 0);
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_sop"}, int'(out_sop), 0);
    chk({tag, "_dout_real"}, int'(dout_real), 0);
    chk({tag, "_dout_imag"}, int'(dout_imag), 0);
    chk({tag, "_sat_flag"}, int'(sat_flag), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    p_rere   = '0;
    p_imim   = '0;
    p_reim   = '0;
    p_imre   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("idle");
    chk("idle_const_sel", int'(const_sel), 0);

    // Full frame with directed products at chosen indices
    for (int i = 0; i < 64; i++) begin
      case (i)
        0:  send(1'b1, 1000, 0, 0, -500, 500, -250, 1'b0);
        18: send(1'b0, 2000, 300, -700, 100, 1150, 400, 1'b0);
        28: send(1'b0, 1000, -200, 400, 600, 500, -600, 1'b0);
        30: send(1'b0, 800, 100, -300, 50, 175, -450, 1'b0);
        42: send(1'b0, -3000, 1500, 2500, -100, 1200, 2250, 1'b0);
        54: send(1'b0, -1000, -1000, 0, 0, 1000, 0, 1'b0);
        63: send(1'b0, 100, 200, 300, 400, -50, 150, 1'b0);
        default: send(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
      endcase
    end

    // Saturation both ways, then a clean sample (flag must drop)
    send(1'b1, 16383, 16383, 0, 0, 8191, 0, 1'b1);
    send(1'b0, -16384, -16384, 0, 0, -8192, 0, 1'b1);
    send(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Mid-frame restart at sample 20
    for (int i = 0; i < 20; i++) send(i == 0, 0, 0, 0, 0, 0, 0, 1'b0);
    send(1'b1, 1000, 0, 0, -500, 500, -250, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Three-cycle gap; in_sop without in_valid must not restart the frame
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    send(1'b0, 2000, 300, -700, 100, 1150, 400, 1'b0);
    for (int i = 0; i < 11; i++) send(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Asynchronous reset with samples in flight
    send(1'b0, 100, 200, 300, 400, 0, 0, 1'b0);
    send(1'b0, 100, 200, 300, 400, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    sb.delete();
    model_cnt = 0;
    last_r    = 0;
    last_i    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Counter must restart at 0 without in_sop; index 9 -> 1*1 = sel 1
    for (int i = 0; i < 9; i++) send(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    send(1'b0, 100, 200, 300, 400, 150, 50, 1'b0);
    idle(1'b0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs missing, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
